// File: rtl/uut_run_sequencer.sv
// ---------------------------------------------------------------------------
// uut_run_sequencer
//
// Sequences one keystream-generator run: latches key/iv/block count on start,
// holds the UUT in reset for RST_CYCLES cycles, then releases it and collects
// one 64-bit block per rising edge of end_uut into a 4-entry FIFO.
// The FIFO is drained towards a ready/valid consumer. The run ends in one of
// three ways: all blocks are collected, the watchdog expires, or the FIFO
// overflows. The UUT is put back into reset while the FIFO empties, and then
// done pulses for one cycle.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   start                run request (honoured only in IDLE)
//   key_i, iv_i          80-bit run parameters, latched on start
//   num_blocks_i         number of blocks to collect, latched on start
//   rst_uut              UUT reset (1 = UUT held in reset)
//   key_uut, iv_uut      latched parameters driven to the UUT
//   block_o_uut, end_uut UUT keystream block and its valid strobe
//   blk_data_o/_index_o  FIFO head entry and its sequence number
//   blk_valid_o          FIFO not empty
//   blk_ready_i          consumer accepts the head entry
//   busy, done           not-IDLE flag, one-cycle completion pulse
//   timeout_err, ovf_err sticky error flags, cleared by an accepted start
//   cycles_o             cycles from UUT release to the first end_uut rise
// ---------------------------------------------------------------------------
module uut_run_sequencer #(
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT_W  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [79:0] key_i,
    input  logic [79:0] iv_i,
    input  logic [7:0]  num_blocks_i,
    output logic        rst_uut,
    output logic [79:0] key_uut,
    output logic [79:0] iv_uut,
    input  logic [63:0] block_o_uut,
    input  logic        end_uut,
    output logic [63:0] blk_data_o,
    output logic        blk_valid_o,
    input  logic        blk_ready_i,
    output logic [7:0]  blk_index_o,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic        ovf_err,
    output logic [31:0] cycles_o
);

    localparam int DATA_W = 64;
    localparam int RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCNT_W-1:0]    RST_LAST = RCNT_W'(RST_CYCLES - 1);
    // Value one below all-ones: the watchdog hits all-ones on the edge that
    // also leaves RUN.
    localparam logic [TIMEOUT_W-1:0] WD_LAST  = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        IDLE,
        UUT_RST,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                state;
    state_t                state_d;
    logic [RCNT_W-1:0]     rst_cnt;
    logic [TIMEOUT_W-1:0]  wdog;
    logic [7:0]            nb;
    logic [7:0]            blk_cnt;
    logic                  first_seen;
    logic                  end_uut_p1;

    logic [DATA_W-1:0]     mem_data [4];
    logic [7:0]            mem_idx  [4];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            fifo_cnt;

    logic                  start_acc;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  ovf;
    logic                  push_ok;
    logic                  last_blk;
    logic                  wd_hit;

    assign start_acc   = (state == IDLE) && start;
    // A rise is end_uut high now and low the cycle before; only counted in RUN.
    assign push        = (state == RUN) && end_uut && !end_uut_p1;
    assign blk_valid_o = (fifo_cnt != 3'd0);
    assign pop         = blk_valid_o && blk_ready_i;
    assign full        = (fifo_cnt == 3'd4);
    // A simultaneous pop frees a slot, so full+push+pop is not an overflow.
    assign ovf         = push && full && !pop;
    assign push_ok     = push && !ovf;
    assign last_blk    = push_ok && ((blk_cnt + 8'd1) == nb);
    assign wd_hit      = (state == RUN) && !push && (wdog == WD_LAST);

    // Head entry is forced to zero when empty so reset clears the outputs
    // without having to reset the storage array.
    assign blk_data_o  = blk_valid_o ? mem_data[rd_ptr] : '0;
    assign blk_index_o = blk_valid_o ? mem_idx[rd_ptr]  : '0;

    always_comb begin
        state_d = state;
        rst_uut = 1'b1;
        busy    = 1'b1;
        done    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = (num_blocks_i == 8'd0) ? DONE : UUT_RST;
                end
            end
            UUT_RST: begin
                if (rst_cnt == RST_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                rst_uut = 1'b0;
                if (ovf || last_blk || wd_hit) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_cnt == 3'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rst_cnt     <= '0;
            wdog        <= '0;
            nb          <= '0;
            blk_cnt     <= '0;
            first_seen  <= 1'b0;
            end_uut_p1  <= 1'b0;
            key_uut     <= '0;
            iv_uut      <= '0;
            cycles_o    <= '0;
            timeout_err <= 1'b0;
            ovf_err     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
        end else begin
            state      <= state_d;
            end_uut_p1 <= end_uut;
            rst_cnt    <= (state == UUT_RST) ? rst_cnt + RCNT_W'(1) : '0;
            // Held at zero outside RUN, so it restarts on RUN entry.
            if ((state == RUN) && !push) begin
                wdog <= wdog + TIMEOUT_W'(1);
            end else begin
                wdog <= '0;
            end

            if (start_acc) begin
                key_uut     <= key_i;
                iv_uut      <= iv_i;
                nb          <= num_blocks_i;
                blk_cnt     <= '0;
                cycles_o    <= '0;
                first_seen  <= 1'b0;
                timeout_err <= 1'b0;
                ovf_err     <= 1'b0;
            end else begin
                if (push_ok) begin
                    blk_cnt <= blk_cnt + 8'd1;
                end
                if (push) begin
                    first_seen <= 1'b1;
                end else if ((state == RUN) && !first_seen && (cycles_o != '1)) begin
                    cycles_o <= cycles_o + 32'd1;
                end
                if (wd_hit) begin
                    timeout_err <= 1'b1;
                end
                if (ovf) begin
                    ovf_err <= 1'b1;
                end
            end

            if (push_ok) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            fifo_cnt <= fifo_cnt + 3'(push_ok) - 3'(pop);
        end
    end

    // FIFO storage: data path, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= block_o_uut;
            mem_idx[wr_ptr]  <= blk_cnt;
        end
    end

endmodule

// File: doc/uut_run_sequencer.md
UUT_RUN_SEQUENCER -- requirements
Module: uut_run_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 4, cycles rst_uut is held high before each run; legal range is 1 or more.
REQ-002 Parameter TIMEOUT_W, default 16, width of the per-block watchdog counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  run request; sampled only in IDLE.
REQ-006 key_i / iv_i  input  80 each  run parameters; latched when start is accepted.
REQ-007 num_blocks_i  input  8  number of 64-bit keystream blocks to collect; latched when start is accepted.
REQ-008 rst_uut  output  1  UUT reset; high means the UUT is held in reset.
REQ-009 key_uut / iv_uut  output  80 each  latched parameters driven to the UUT.
REQ-010 block_o_uut  input  64  UUT keystream block.
REQ-011 end_uut  input  1  high while block_o_uut is valid.
REQ-012 blk_data_o  output  64  head entry of the FIFO.
REQ-013 blk_valid_o  output  1  FIFO is not empty.
REQ-014 blk_ready_i  input  1  consumer accepts the head entry.
REQ-015 blk_index_o  output  8  sequence number of the head entry, starting at 0.
REQ-016 busy  output  1  high in every state other than IDLE.
REQ-017 done  output  1  one-cycle pulse when a run completes.
REQ-018 timeout_err / ovf_err  output  1 each  sticky error flags, cleared by the next accepted start.
REQ-019 cycles_o  output  32  clk cycles from rst_uut release to the first end_uut rise.

Function
REQ-020 States SHALL be IDLE, UUT_RST, RUN, DRAIN, DONE.
REQ-021 IDLE: start=1 latches key/iv/num_blocks, clears the error flags, cycles_o and the block counter, and moves to UUT_RST; it moves to DONE instead if num_blocks_i is 0.
REQ-022 A start asserted outside IDLE SHALL be ignored.
REQ-023 UUT_RST: rst_uut high for exactly RST_CYCLES cycles, then move to RUN.
REQ-024 RUN: rst_uut low; cycles_o increments every cycle until the first end_uut rise, then freezes (saturating at all-ones).
REQ-025 An end_uut rise SHALL be detected as end_uut=1 with its registered previous value 0; a held-high end_uut counts once.
REQ-026 On each rise, block_o_uut of that cycle SHALL be pushed into the 4-entry FIFO together with its index, and the block counter incremented.
REQ-027 When the block counter reaches num_blocks, the FSM SHALL move to DRAIN.
REQ-028 The watchdog SHALL reset on entering RUN and on each rise, and count otherwise.
REQ-029 If the watchdog reaches 2^TIMEOUT_W-1, timeout_err SHALL set and the FSM SHALL move to DRAIN.
REQ-030 A push while the FIFO is full with no pop in the same cycle SHALL drop the block, set ovf_err and move to DRAIN.
REQ-031 Push and pop in the same cycle when full is legal and is not an overflow.
REQ-032 Pop occurs when blk_valid_o and blk_ready_i are both 1.
REQ-033 blk_data_o and blk_index_o SHALL be stable while blk_valid_o=1 and blk_ready_i=0.
REQ-034 Latency from an end_uut rise into an empty FIFO to blk_valid_o=1 is 1 cycle.
REQ-035 DRAIN: rst_uut high; stay until the FIFO is empty, then move to DONE.
REQ-036 DONE: done=1 for one cycle, rst_uut high, then return to IDLE.
REQ-037 The FIFO pointers SHALL wrap modulo 4; the occupancy count is 3 bits.

Reset
REQ-038 rst=1 SHALL asynchronously force state IDLE, rst_uut=1, and clear the FIFO.
REQ-039 rst=1 SHALL asynchronously set to 0: key_uut, iv_uut, blk_valid_o, blk_data_o, blk_index_o, busy, done, both error flags and cycles_o.
REQ-040 A reset asserted mid-run SHALL abandon the run: no done pulse and no partial data afterwards.

Verification
REQ-041 Normal run: num_blocks=3, RST_CYCLES=4, UUT rises 1152, 1216 and 1280 cycles after release, consumer always ready -> rst_uut high 4 cycles, then indices 0,1,2 with matching data, cycles_o=1152, one done pulse, no error flags.
REQ-042 Backpressure: num_blocks=6, blk_ready_i=0 until 4 blocks are buffered, then 1 in the cycle of the 5th rise -> no ovf_err, all 6 blocks delivered in order.
REQ-043 Overflow: num_blocks=6, blk_ready_i=0 throughout -> ovf_err=1 on the 5th rise, DRAIN then holds 4 entries until ready, then done.
REQ-044 Timeout: TIMEOUT_W=8, end_uut never rises -> timeout_err=1 after 255 RUN cycles, rst_uut=1, done pulse, no blocks.
REQ-045 Edge cases: num_blocks=0 -> done within 2 cycles and rst_uut never low; end_uut held high 10 cycles -> exactly one push; start while busy -> ignored.
REQ-046 Reset mid-RUN with 2 blocks buffered -> blk_valid_o=0 and rst_uut=1 immediately, state IDLE, no done pulse.
